// File: rtl/axis_uart_tx.sv
// AXI-Stream byte sink that buffers beats in a small FIFO and serialises them
// as start / DATA_WIDTH data bits (LSB first) / stop characters on tx.
//
// state | meaning
// IDLE  | line high, waiting for the FIFO to hold a beat
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | data bits, LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (high); reloads straight into START when more data waits
module axis_uart_tx #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   output logic                  s_axis_tready,
   output logic                  tx,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = PTR_W + 1;
   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t                state;
   logic [BAUD_W-1:0]     baud_cnt;
   logic [BIT_W-1:0]      bit_cnt;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic                  last_flag;
   logic                  done_q;

   // each entry holds {tlast, tdata}
   logic [DATA_WIDTH:0]   fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic [CNT_W-1:0]      count_nx;
   logic [DATA_WIDTH:0]   rd_entry;

   logic push;
   logic pop;
   logic fifo_empty;
   logic baud_end;
   logic leaving_stop;
   logic active_nx;

   always_comb begin
      push         = s_axis_tvalid && s_axis_tready;
      fifo_empty   = (count == '0);
      baud_end     = (baud_cnt == BAUD_LAST);
      leaving_stop = (state == STOP) && baud_end;
      pop          = !fifo_empty && ((state == IDLE) || leaving_stop);
      rd_entry     = fifo_mem[rd_ptr];

      count_nx = count;
      if (push && !pop) begin
         count_nx = count + CNT_W'(1);
      end else if (pop && !push) begin
         count_nx = count - CNT_W'(1);
      end

      // FSM will be out of IDLE after this edge
      active_nx = pop || ((state != IDLE) && !leaving_stop);
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {s_axis_tlast, s_axis_tdata};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         s_axis_tready <= 1'b0;
         busy          <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count         <= count_nx;
         s_axis_tready <= (count_nx != CNT_FULL);
         busy          <= active_nx || (count_nx != '0);
      end
   end

   // tx and frame_done trail the state by one cycle so both line up with
   // the edge where the previous bit actually ends on the wire
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         baud_cnt   <= '0;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         last_flag  <= 1'b0;
         done_q     <= 1'b0;
         frame_done <= 1'b0;
         tx         <= 1'b1;
      end else begin
         done_q     <= leaving_stop && last_flag;
         frame_done <= done_q;

         case (state)
            IDLE: begin
               tx       <= 1'b1;
               baud_cnt <= '0;
               bit_cnt  <= '0;
               if (pop) begin
                  shift_reg <= rd_entry[DATA_WIDTH-1:0];
                  last_flag <= rd_entry[DATA_WIDTH];
                  state     <= START;
               end
            end

            START: begin
               tx <= 1'b0;
               if (baud_end) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end

            DATA: begin
               tx <= shift_reg[0];
               if (baud_end) begin
                  baud_cnt  <= '0;
                  shift_reg <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt <= '0;
                     state   <= STOP;
                  end else begin
                     bit_cnt <= bit_cnt + BIT_W'(1);
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end

            STOP: begin
               tx <= 1'b1;
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (pop) begin
                     shift_reg <= rd_entry[DATA_WIDTH-1:0];
                     last_flag <= rd_entry[DATA_WIDTH];
                     state     <= START;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end

            default: begin
               tx    <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axis_uart_tx.sv
// Bench for axis_uart_tx: directed beats feed an expected queue; a tx-line
// monitor decodes each character and pops/compares it, including frame_done.
module tb_axis_uart_tx;

   localparam int DW   = 8;
   localparam int CPB  = 4;
   localparam int DEP  = 4;
   localparam int CHAR = (DW + 2) * CPB;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] s_axis_tdata;
   logic          s_axis_tvalid;
   logic          s_axis_tlast;
   logic          s_axis_tready;
   logic          tx;
   logic          busy;
   logic          frame_done;

   axis_uart_tx #(
      .DATA_WIDTH  (DW),
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (DEP)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast (s_axis_tlast),
      .s_axis_tready(s_axis_tready),
      .tx           (tx),
      .busy         (busy),
      .frame_done   (frame_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   int last_acc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   logic [DW:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic          mon_in_char = 1'b0;
   logic          mon_pend    = 1'b0;
   logic          mon_pend_last;
   logic          mon_unexp;
   int            mon_c       = 0;
   int            mon_start   = 0;
   int            n_chars     = 0;
   int            n_fd        = 0;
   int            n_contig    = 0;
   logic [DW:0]   mon_exp;
   logic [CHAR-1:0] samp;

   always @(negedge clk) begin
      if (rst) begin
         mon_in_char = 1'b0;
         mon_pend    = 1'b0;
      end else begin
         if (frame_done === 1'b1) n_fd++;
         if (mon_pend) begin
            chk("frame_done_at_stop_end", frame_done, mon_pend_last);
            if (tx === 1'b0) n_contig++;
            mon_pend = 1'b0;
         end
         if (!mon_in_char && tx === 1'b0) begin
            mon_in_char = 1'b1;
            mon_c       = 0;
            mon_start   = cyc;
            mon_unexp   = 1'b0;
            if (exp_q.size() == 0) begin
               mon_unexp = 1'b1;
               mon_exp   = '0;
               n_checks++;
               n_err++;
               $display("FAIL unexpected_char: start bit seen at cycle %0d, required line idle", cyc);
            end else begin
               mon_exp = exp_q.pop_front();
            end
         end
         if (mon_in_char) begin
            samp[mon_c] = tx;
            mon_c++;
            if (mon_c == CHAR) begin
               logic [DW+1:0] mids;
               int glitch;
               glitch = 0;
               for (int b = 0; b < DW + 2; b++) begin
                  mids[b] = samp[b*CPB + 2];
                  for (int k = 0; k < CPB; k++)
                     if (samp[b*CPB + k] !== mids[b]) glitch++;
               end
               mon_in_char = 1'b0;
               if (!mon_unexp) begin
                  n_chars++;
                  chk("char_data", {24'd0, mids[DW:1]}, {24'd0, mon_exp[DW-1:0]});
                  chk("char_framing", {mids[0], mids[DW+1], glitch == 0}, 3'b011);
                  mon_pend      = 1'b1;
                  mon_pend_last = mon_exp[DW];
               end
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic align();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] d, input logic l, input int gap);
      logic rdy;
      logic ok;
      if (gap > 0) begin
         s_axis_tvalid = 1'b0;
         repeat (gap) @(posedge clk);
         #1;
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tlast  = l;
      ok = 1'b0;
      for (int t = 0; t < 500 && !ok; t++) begin
         @(negedge clk);
         rdy = s_axis_tready;
         @(posedge clk);
         if (rdy) ok = 1'b1;
      end
      #1;
      if (ok) begin
         exp_q.push_back({l, d});
         last_acc = cyc;
      end
      chk("beat_accepted", ok, 1'b1);
   endtask

   task automatic wait_idle(input int budget);
      logic done;
      done = 1'b0;
      for (int t = 0; t < budget && !done; t++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !mon_in_char && !mon_pend && busy === 1'b0) done = 1'b1;
      end
      chk("idle_reached", done, 1'b1);
   endtask

   int ch0, fd0, ct0;

   task automatic snap();
      ch0 = n_chars;
      fd0 = n_fd;
      ct0 = n_contig;
   endtask

   task automatic scen_end(input string name, input int e_ch, input int e_fd, input int e_ct);
      chk({name, "_chars"}, n_chars - ch0, e_ch);
      chk({name, "_frame_done_count"}, n_fd - fd0, e_fd);
      chk({name, "_contiguous"}, n_contig - ct0, e_ct);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      int acc_base;
      int acc5;
      int bad;
      rst           = 1'b1;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tlast  = 1'b0;

      // reset state and first-edge tready
      repeat (3) @(negedge clk);
      chk("reset_tx", tx, 1'b1);
      chk("reset_tready", s_axis_tready, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_frame_done", frame_done, 1'b0);
      rst = 1'b0;
      #1;
      chk("tready_before_first_edge", s_axis_tready, 1'b0);
      align();
      chk("tready_after_first_edge", s_axis_tready, 1'b1);

      // single beat 0xA5 with tlast
      snap();
      send(8'hA5, 1'b1, 0);
      s_axis_tvalid = 1'b0;
      wait_idle(300);
      chk("start_latency", mon_start - last_acc, 2);
      repeat (3) @(negedge clk);
      chk("busy_after_a5", busy, 1'b0);
      scen_end("a5", 1, 1, 0);

      // tvalid held with 0x01..0x06, tlast on 0x06
      snap();
      align();
      send(8'h01, 1'b0, 0);
      acc_base = last_acc;
      send(8'h02, 1'b0, 0);
      send(8'h03, 1'b0, 0);
      send(8'h04, 1'b0, 0);
      send(8'h05, 1'b0, 0);
      acc5 = last_acc - acc_base;
      send(8'h06, 1'b1, 0);
      s_axis_tvalid = 1'b0;
      chk("fill_accept_offset_beat5", acc5, 4);
      chk("refill_accept_offset_beat6", last_acc - acc_base, 42);
      wait_idle(1000);
      scen_end("held", 6, 1, 5);

      // random gaps, 3-byte frame
      snap();
      align();
      send(8'h10, 1'b0, $urandom_range(1, 3));
      send(8'h20, 1'b0, $urandom_range(1, 3));
      send(8'h30, 1'b1, $urandom_range(1, 3));
      s_axis_tvalid = 1'b0;
      wait_idle(600);
      scen_end("gaps", 3, 1, 2);

      // two frames back to back
      snap();
      align();
      send(8'h55, 1'b1, 0);
      send(8'hAA, 1'b0, 0);
      send(8'h0F, 1'b1, 0);
      s_axis_tvalid = 1'b0;
      wait_idle(600);
      scen_end("b2b", 3, 2, 2);

      // reset during data bit 3 of 0xFF with 0x3C queued
      snap();
      align();
      send(8'hFF, 1'b0, 0);
      send(8'h3C, 1'b1, 0);
      s_axis_tvalid = 1'b0;
      begin
         logic hit;
         hit = 1'b0;
         for (int t = 0; t < 200 && !hit; t++) begin
            @(negedge clk);
            if (mon_in_char && mon_c >= 17 && mon_c <= 19) hit = 1'b1;
         end
         chk("reached_data_bit3", hit, 1'b1);
      end
      #1;
      rst = 1'b1;
      #1;
      exp_q.delete();
      chk("midrst_tx", tx, 1'b1);
      chk("midrst_tready", s_axis_tready, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_tready_before_edge", s_axis_tready, 1'b0);
      align();
      chk("midrst_tready_after_edge", s_axis_tready, 1'b1);
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      chk("midrst_line_quiet", bad, 0);
      scen_end("midrst", 0, 0, 0);

      // tdata toggling with tvalid low
      snap();
      align();
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         s_axis_tdata = DW'(i * 37 + 5);
         s_axis_tlast = i[0];
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || s_axis_tready !== 1'b1) bad++;
         @(posedge clk);
         #1;
      end
      chk("tvalid_low_quiet", bad, 0);
      repeat (60) @(negedge clk);
      chk("tvalid_low_busy", busy, 1'b0);
      scen_end("novalid", 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
